// File: rtl/present_arb_pkg.sv
// Shared types and sizes for the PRESENT core arbiter.
package present_arb_pkg;

  localparam int unsigned PT_W               = 64;
  localparam int unsigned KEY_W              = 80;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  // One-hot two-way grant to requester index; bit 1 set means requester 1.
  function automatic logic grant_to_id(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/present_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that was not served last wins.
module present_rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end else if (valid0_i) begin
      grant_o = 2'b01;
    end else if (valid1_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/present_arbiter.sv
// Arbiter sharing one PRESENT encrypt core between two requesters, one job in flight.
// Define PRESENT_ARB_TIMEOUT_EN to bound RUN and answer with rsp_error after TIMEOUT_CYCLES.
module present_arbiter
  import present_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [PT_W-1:0]  req0_plaintext,
  input  logic [KEY_W-1:0] req0_key,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [PT_W-1:0]  req1_plaintext,
  input  logic [KEY_W-1:0] req1_key,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [PT_W-1:0]  rsp_ciphertext,
  output logic             rsp_error,

  output logic [PT_W-1:0]  core_plaintext,
  output logic [KEY_W-1:0] core_key,
  output logic             core_reset,
  input  logic             core_ready,
  input  logic [PT_W-1:0]  core_ciphertext
);

  // A one-cycle budget would expire in the cycle whose core_ready is stale.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("present_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e       state_q;
  logic             last_q;
  logic [PT_W-1:0]  pt_q;
  logic [KEY_W-1:0] key_q;
  logic             id_q;
  logic             run_first_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [PT_W-1:0]  rsp_ct_q;

  logic [1:0]       grant;
  logic             idle;
  logic             accept_d;
  logic             accept_id_d;

  present_rr_arb2 u_rr (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .last_i   (last_q),
    .grant_o  (grant)
  );

  assign idle        = (state_q == ST_IDLE) && !reset;
  assign req0_ready  = idle && grant[0];
  assign req1_ready  = idle && grant[1];
  assign accept_d    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign accept_id_d = grant_to_id(grant);

  assign core_plaintext = pt_q;
  assign core_key       = key_q;
  assign core_reset     = reset || (state_q == ST_LOAD);

  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_ciphertext = rsp_ct_q;

`ifdef PRESENT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] run_cnt_q;
  logic             rsp_err_q;

  assign rsp_error = rsp_err_q;
`else
  assign rsp_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      pt_q        <= '0;
      key_q       <= '0;
      id_q        <= 1'b0;
      run_first_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_ct_q    <= '0;
`ifdef PRESENT_ARB_TIMEOUT_EN
      run_cnt_q   <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            pt_q    <= accept_id_d ? req1_plaintext : req0_plaintext;
            key_q   <= accept_id_d ? req1_key : req0_key;
            id_q    <= accept_id_d;
            state_q <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          run_first_q <= 1'b1;
`ifdef PRESENT_ARB_TIMEOUT_EN
          run_cnt_q   <= '0;
`endif
          state_q     <= ST_RUN;
        end

        ST_RUN: begin
          run_first_q <= 1'b0;
          // core_ready in the first RUN cycle still reflects the previous job.
          if (!run_first_q && core_ready) begin
            rsp_ct_q    <= core_ciphertext;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
`ifdef PRESENT_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= ST_DONE;
          end
`ifdef PRESENT_ARB_TIMEOUT_EN
          else if (run_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_ct_q    <= '0;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            run_cnt_q <= run_cnt_q + CNT_W'(1);
          end
`endif
        end

        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            last_q      <= id_q;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
